// File: rtl/serial_twos_complementer_n.sv
// -----------------------------------------------------------------------------
// serial_twos_complementer_n
//
// Loads a parallel WIDTH-bit word and shifts it out LSB first, one bit per
// enabled clock edge. In complement mode (mode=1) the emitted stream is the
// two's complement of the word, using "copy through the first 1, invert the
// rest". In pass mode (mode=0) the word is emitted unchanged. The emitted
// stream is also collected into a parallel result. The block flags the
// most-negative input value, whose complement is itself.
//
// State table:
//   state | meaning
//   IDLE  | no conversion loaded
//   SHIFT | bits remain to be emitted
//   DONE  | all WIDTH bits emitted; outputs hold until the next load
//
// Ports:
//   Clock         in   1      rising-edge clock
//   reset_b       in   1      asynchronous active-low reset
//   data          in   WIDTH  parallel word, sampled when load=1
//   load          in   1      capture data/mode and start (also aborts a run)
//   mode          in   1      1 = two's complement, 0 = pass-through
//   shift_control in   1      shift enable while in SHIFT
//   y             out  1      registered serial output bit
//   y_valid       out  1      one-cycle pulse per newly emitted bit
//   busy          out  1      high in SHIFT
//   done          out  1      high in DONE
//   result        out  WIDTH  parallel copy of the emitted stream
//   overflow      out  1      complement of the most-negative value
// -----------------------------------------------------------------------------
module serial_twos_complementer_n #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             Clock,
    input  logic             reset_b,
    input  logic [WIDTH-1:0] data,
    input  logic             load,
    input  logic             mode,
    input  logic             shift_control,
    output logic             y,
    output logic             y_valid,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sreg_q;
    logic [WIDTH-1:0] result_q;
    logic [CW-1:0]    cnt_q;
    logic             seen_one_q;
    logic             mode_q;
    logic             y_q;
    logic             y_valid_q;
    logic             overflow_q;

    logic             bit_d;
    logic             out_bit_d;
    logic             last_d;

    assign bit_d     = sreg_q[0];
    // Once a 1 has gone out, every later bit is inverted in complement mode.
    assign out_bit_d = (mode_q & seen_one_q) ? ~bit_d : bit_d;
    assign last_d    = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge Clock or negedge reset_b) begin
        if (!reset_b) begin
            state_q    <= IDLE;
            sreg_q     <= '0;
            result_q   <= '0;
            cnt_q      <= '0;
            seen_one_q <= 1'b0;
            mode_q     <= 1'b0;
            y_q        <= 1'b0;
            y_valid_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            y_valid_q <= 1'b0;
            if (load) begin
                // Load wins over shifting on the same edge; no bit goes out.
                state_q    <= SHIFT;
                sreg_q     <= data;
                mode_q     <= mode;
                cnt_q      <= '0;
                seen_one_q <= 1'b0;
                result_q   <= '0;
                overflow_q <= 1'b0;
            end else begin
                case (state_q)
                    SHIFT: begin
                        if (shift_control) begin
                            y_q        <= out_bit_d;
                            y_valid_q  <= 1'b1;
                            sreg_q     <= sreg_q >> 1;
                            result_q   <= {out_bit_d, result_q[WIDTH-1:1]};
                            seen_one_q <= seen_one_q | bit_d;
                            cnt_q      <= cnt_q + CW'(1);
                            if (last_d) begin
                                state_q    <= DONE;
                                // No earlier 1 and the MSB is 1: the word is
                                // 100..0, which complements to itself.
                                overflow_q <= mode_q & bit_d & ~seen_one_q;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign y        = y_q;
    assign y_valid  = y_valid_q;
    assign busy     = (state_q == SHIFT);
    assign done     = (state_q == DONE);
    assign result   = result_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_serial_twos_complementer_n.sv
module tb_serial_twos_complementer_n;

    logic       Clock;
    logic       reset_b;

    // WIDTH=8 instance
    logic [7:0] data8;
    logic       load8, mode8, sc8;
    logic       y8, yv8, busy8, done8, ovf8;
    logic [7:0] res8;

    // WIDTH=4 instance
    logic [3:0] data4;
    logic       load4, mode4, sc4;
    logic       y4, yv4, busy4, done4, ovf4;
    logic [3:0] res4;

    int total = 0;
    int bad   = 0;

    serial_twos_complementer_n #(.WIDTH(8)) dut8 (
        .Clock(Clock), .reset_b(reset_b), .data(data8), .load(load8),
        .mode(mode8), .shift_control(sc8), .y(y8), .y_valid(yv8),
        .busy(busy8), .done(done8), .result(res8), .overflow(ovf8)
    );

    serial_twos_complementer_n #(.WIDTH(4)) dut4 (
        .Clock(Clock), .reset_b(reset_b), .data(data4), .load(load4),
        .mode(mode4), .shift_control(sc4), .y(y4), .y_valid(yv4),
        .busy(busy4), .done(done4), .result(res4), .overflow(ovf4)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Full conversion on the 8-bit instance, shift_control held high.
    // exp_res is hand-computed; its bit i is also the i-th expected y bit.
    task automatic conv8(input string tag, input logic [7:0] d, input logic m,
                         input logic [7:0] exp_res, input logic exp_ovf);
        data8 = d; mode8 = m; load8 = 1'b1; sc8 = 1'b1;
        tick();
        load8 = 1'b0;
        chk({tag, "_busy_after_load"}, busy8, 1);
        chk({tag, "_done_after_load"}, done8, 0);
        chk({tag, "_yv_on_load"}, yv8, 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk({tag, "_y"}, y8, exp_res[i]);
            chk({tag, "_yv"}, yv8, 1);
            if (i < 7) chk({tag, "_busy_mid"}, busy8, 1);
        end
        chk({tag, "_done"}, done8, 1);
        chk({tag, "_busy_end"}, busy8, 0);
        chk({tag, "_result"}, res8, exp_res);
        chk({tag, "_ovf"}, ovf8, exp_ovf);
    endtask

    task automatic conv4(input string tag, input logic [3:0] d, input logic m,
                         input logic [3:0] exp_res, input logic exp_ovf);
        data4 = d; mode4 = m; load4 = 1'b1; sc4 = 1'b1;
        tick();
        load4 = 1'b0;
        chk({tag, "_busy_after_load"}, busy4, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk({tag, "_y"}, y4, exp_res[i]);
            chk({tag, "_yv"}, yv4, 1);
        end
        chk({tag, "_done"}, done4, 1);
        chk({tag, "_result"}, res4, exp_res);
        chk({tag, "_ovf"}, ovf4, exp_ovf);
    endtask

    initial begin
        reset_b = 1'b0;
        data8 = '0; load8 = 0; mode8 = 0; sc8 = 0;
        data4 = '0; load4 = 0; mode4 = 0; sc4 = 0;
        #23;
        chk("rst_y", y8, 0);
        chk("rst_yv", yv8, 0);
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_result", res8, 0);
        chk("rst_ovf", ovf8, 0);
        chk("rst4_busy", busy4, 0);
        chk("rst4_result", res4, 0);
        reset_b = 1'b1;
        tick();

        // IDLE ignores shift_control
        sc8 = 1'b1;
        tick(); tick();
        chk("idle_busy", busy8, 0);
        chk("idle_yv", yv8, 0);

        // 0x06 complement -> 0xFA, stream 0,1,0,1,1,1,1,1
        conv8("c06", 8'h06, 1'b1, 8'hFA, 1'b0);
        // DONE ignores shift_control and holds
        tick();
        chk("done_hold", done8, 1);
        chk("done_hold_yv", yv8, 0);
        chk("done_hold_res", res8, 8'hFA);

        conv8("c80", 8'h80, 1'b1, 8'h80, 1'b1);
        // loaded in the first DONE cycle of the previous run (back-to-back)
        conv8("c00", 8'h00, 1'b1, 8'h00, 1'b0);
        conv8("pA5", 8'hA5, 1'b0, 8'hA5, 1'b0);
        conv8("p80", 8'h80, 1'b0, 8'h80, 1'b0);

        // Stall: 0x01 complement -> 0xFF, stall 3 cycles after the 4th bit
        data8 = 8'h01; mode8 = 1'b1; load8 = 1'b1; sc8 = 1'b1;
        tick();
        load8 = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("stall_y4", y8, 1);
        sc8 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_yv", yv8, 0);
            chk("stall_y", y8, 1);
            chk("stall_busy", busy8, 1);
        end
        sc8 = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("stall_notdone", done8, 0);
        tick();
        chk("stall_done", done8, 1);
        chk("stall_result", res8, 8'hFF);
        chk("stall_ovf", ovf8, 0);

        // Abort: 0x06, reload 0x03 after the 3rd bit, reset after 2 new bits
        data8 = 8'h06; mode8 = 1'b1; load8 = 1'b1; sc8 = 1'b1;
        tick();
        load8 = 1'b0;
        tick(); tick(); tick();
        chk("abort_y3", y8, 0);
        data8 = 8'h03; load8 = 1'b1;
        tick();
        load8 = 1'b0;
        chk("abort_yv", yv8, 0);
        chk("abort_busy", busy8, 1);
        chk("abort_result", res8, 0);
        tick();
        chk("abort_nb0", y8, 1);
        tick();
        chk("abort_nb1", y8, 0);
        chk("abort_res2", res8, 8'h40);
        #2;
        reset_b = 1'b0;
        #1;
        chk("arst_busy", busy8, 0);
        chk("arst_done", done8, 0);
        chk("arst_y", y8, 0);
        chk("arst_yv", yv8, 0);
        chk("arst_result", res8, 0);
        chk("arst_ovf", ovf8, 0);
        #3;
        reset_b = 1'b1;
        tick();
        chk("arst_idle", busy8, 0);
        conv8("c03", 8'h03, 1'b1, 8'hFD, 1'b0);

        // 4-bit instance
        conv4("w4_5", 4'h5, 1'b1, 4'hB, 1'b0);
        conv4("w4_8", 4'h8, 1'b1, 4'h8, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
